// File: rtl/imem_fetch_responder.sv
// Instruction memory with a valid/ready fetch request channel, a held response and a loader port.
// Define IMEM_STATS_EN to build the fetch/fault counters behind stat_fetch_cnt/stat_fault_cnt.
module imem_fetch_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_fault,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] stat_fetch_cnt,
    output logic [15:0] stat_fault_cnt
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic        fault_q, fault_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic req_fault, ld_ok, accept;

    assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
    assign ld_ok     = ld_en && (ld_addr[1:0] == 2'b00) && (ld_addr[31:AW+2] == '0);

    // Loader wins over a fetch in the same cycle, so a read never races a write.
    assign req_ready = !rst && !ld_en &&
                       ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
    assign accept    = req_valid && req_ready;

    assign rsp_valid = (state_q == StResp);
    assign rsp_instr = instr_q;
    assign rsp_addr  = addr_q;
    assign rsp_fault = fault_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: ;
            StWait: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = StResp;
            end
            StResp: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Word is captured at accept so later loader writes cannot disturb this response.
        if (accept) begin
            state_d = (LATENCY == 1) ? StResp : StWait;
            cnt_d   = 2'(LATENCY - 1);
            instr_d = req_fault ? NOP_INSTR : mem[req_addr[AW+1:2]];
            addr_d  = req_addr;
            fault_d = req_fault;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            instr_q <= NOP_INSTR;
            addr_q  <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_ok) mem[ld_addr[AW+1:2]] <= ld_data;
    end

`ifdef IMEM_STATS_EN
    logic        rsp_hs;
    logic [31:0] fetch_cnt_q;
    logic [15:0] fault_cnt_q;

    assign rsp_hs = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            fault_cnt_q <= 16'd0;
        end else if (rsp_hs) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (fault_q && (fault_cnt_q != 16'hFFFF)) fault_cnt_q <= fault_cnt_q + 16'd1;
        end
    end

    assign stat_fetch_cnt = fetch_cnt_q;
    assign stat_fault_cnt = fault_cnt_q;
`else
    assign stat_fetch_cnt = 32'd0;
    assign stat_fault_cnt = 16'd0;
`endif

endmodule
